// File: rtl/pipe_mux_pkg.sv
// Shared types and helpers for the pipe_mux word selector and its skid buffer.
// The buffer entry type is a macro because packages cannot take parameters.

`ifndef PIPE_MUX_PKG_SV
`define PIPE_MUX_PKG_SV

package pipe_mux_pkg;

  // Selector width for an n-way choice; a 1-way choice still needs one wire.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_FULL  = 2'd2
  } fill_e;

endpackage

`define PIPE_MUX_ENTRY_T(W) struct packed { logic err; logic [(W)-1:0] data; }

`endif

// File: rtl/pipe_mux_skid.sv
// Two-entry valid/ready skid buffer, generic in payload width.
// in_ready depends only on registered occupancy (and reset), never on out_ready.

module pipe_mux_skid
  import pipe_mux_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  fill_e        state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign in_ready  = (state_q != FILL_FULL) && rst_n;
  assign out_valid = (state_q != FILL_EMPTY);
  assign out_data  = head_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves it unassigned (no latch).
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      FILL_EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = FILL_ONE;
        end
      end
      FILL_ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          state_d = FILL_FULL;
        end else if (pop) begin
          state_d = FILL_EMPTY;
        end
      end
      FILL_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = FILL_ONE;
        end
      end
      default: state_d = FILL_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= FILL_EMPTY;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end

  // NOTE: the second slot is not reset; it is only read when occupancy is FULL, after a write.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

endmodule

// File: rtl/pipe_mux.sv
// Registered N_IN-way word selector feeding a 2-entry skid buffer, with out-of-range flagging.
// Optional saturating error counter (ports err_cnt/err_clr) when PIPE_MUX_ERR_CNT_EN is defined.

module pipe_mux
  import pipe_mux_pkg::*;
#(
  parameter  int N_IN  = 5,
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 8,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef PIPE_MUX_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]      err_cnt,
  input  logic                  err_clr
`endif
);

  typedef `PIPE_MUX_ENTRY_T(WIDTH) entry_t;
  localparam int ENTRY_W = $bits(entry_t);

  if (N_IN < 2) begin : g_bad_n_in
    $error("pipe_mux: N_IN must be >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_mux: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_mux: CNT_W must be >= 1");
  end

  entry_t in_entry;
  entry_t out_entry;

  // Unmatched selector codes (only when N_IN is not a power of two) yield a zero word with err set.
  always_comb begin
    in_entry.data = '0;
    in_entry.err  = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        in_entry.data = in_data[i*WIDTH +: WIDTH];
        in_entry.err  = 1'b0;
      end
    end
  end

  pipe_mux_skid #(
    .W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_entry),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_entry),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_data = out_entry.data;
  assign out_err  = out_entry.err;

`ifdef PIPE_MUX_ERR_CNT_EN
  logic push_err;

  assign push_err = in_valid && in_ready && in_entry.err;

  // Clear takes priority over a simultaneous erroneous push; the count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (push_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// Scoreboard bench for pipe_mux (N_IN=5, WIDTH=8, CNT_W=4): directed cases plus random backpressure.
// Counter cases are exercised when PIPE_MUX_ERR_CNT_EN is defined.

module tb_pipe_mux;

  localparam int N_IN  = 5;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic                  clk;
  logic                  rst_n;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [2:0]            in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;
`ifdef PIPE_MUX_ERR_CNT_EN
  logic [CNT_W-1:0]      err_cnt;
  logic                  err_clr;
`endif

  pipe_mux #(
    .N_IN  (N_IN),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPE_MUX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             err;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: word s of the flattened bus, or a zero word with err when s names no input.
  function automatic exp_t model(input logic [N_IN*WIDTH-1:0] d, input logic [2:0] s);
    exp_t        e;
    int unsigned idx;
    idx = s;
    if (idx < N_IN) begin
      e.data = WIDTH'((d >> (idx * WIDTH)) & ((1 << WIDTH) - 1));
      e.err  = 1'b0;
    end else begin
      e.data = '0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // Inputs change at posedge+1; both handshakes are observed at the following negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus-side recorder: expected responses enter the queue when a push is seen.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(model(in_data, in_sel));
    end
  end

  // Monitor: every completed output transfer is checked against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got data 0x%0h err %0b, expected no output (t=%0t)",
                 out_data, out_err, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 32'(out_data), 32'(e.data));
        check("sb_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit accepted;

    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef PIPE_MUX_ERR_CNT_EN
    err_clr   = 1'b0;
`endif

    // Reset state.
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
`ifdef PIPE_MUX_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Test 1: single in-range push, one-cycle latency.
    tick();
    in_data   = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    in_sel    = 3'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_data", 32'(out_data), 32'h13);
    check("t1_out_err", 32'(out_err), 32'd0);
    tick();
    @(negedge clk);
    check("t1_drained", 32'(out_valid), 32'd0);

    // Test 2: out-of-range selector.
    tick();
    in_sel   = 3'd6;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_out_data", 32'(out_data), 32'h00);
    check("t2_out_err", 32'(out_err), 32'd1);
`ifdef PIPE_MUX_ERR_CNT_EN
    check("t2_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Test 3: fill under backpressure, then release.
    tick();
    out_ready = 1'b0;
    in_sel    = 3'd0;
    in_valid  = 1'b1;
    tick();
    in_sel = 3'd1;
    tick();
    in_sel = 3'd2;
    @(negedge clk);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    check("t3_hold_ready", 32'(in_ready), 32'd0);
    check("t3_hold_data", 32'(out_data), 32'h10);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_head", 32'(out_data), 32'h10);
    accepted = 1'b0;
    for (int n = 0; n < 8 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
    end
    check("t3_accept", 32'(accepted), 32'd1);
    check("t3_second", 32'(out_data), 32'h11);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Test 4: full-rate streaming.
    for (int i = 0; i < 20; i++) begin
      tick();
      in_sel    = 3'(i % 5);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) check("t4_latency", 32'(out_data), 32'h10 + 32'((i - 1) % 5));
    end
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Test 5: reset with two entries held.
    out_ready = 1'b0;
    in_sel    = 3'd0;
    in_valid  = 1'b1;
    tick();
    in_sel = 3'd1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_full", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_data", 32'(out_data), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    check("t5_quiet", 32'(out_valid), 32'd0);

`ifdef PIPE_MUX_ERR_CNT_EN
    // Test 6: counter saturation and clear priority.
    tick();
    err_clr = 1'b1;
    tick();
    err_clr  = 1'b0;
    in_sel   = 3'd7;
    in_valid = 1'b1;
    repeat (20) tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_saturate", 32'(err_cnt), 32'hF);
    tick();
    in_valid = 1'b1;
    err_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    @(negedge clk);
    check("t6_clear_wins", 32'(err_cnt), 32'd0);
    repeat (3) tick();
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      tick();
      in_data   = {$urandom, $urandom};
      in_sel    = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    #2;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
